// File: rtl/cq_req_ctrl.sv
// cq_req_ctrl: turns parsed BAR0 requests into register-file accesses.
// Writes are posted straight to the register write port. Reads are queued in
// a small FIFO and served one at a time by a read FSM that issues the register
// read, waits (with timeout) for the data and then holds a completion request
// until the completer accepts it.
// Ports:
//   user_clk, user_reset              clock, async active-high reset
//   cq_*                              parsed request (no backpressure)
//   reg_wr_en/addr/data               register write port
//   reg_rd_en/addr, reg_rd_valid/data register read port, variable latency
//   cpl_* , cpl_ready                 completion request handshake
//   rd_drop_cnt, rd_timeout_cnt       saturating status counters
module cq_req_ctrl #(
    parameter int unsigned BAR0_SIZE     = 16,
    parameter int unsigned RD_FIFO_DEPTH = 4,
    parameter int unsigned RD_TIMEOUT    = 255
) (
    input  logic                 user_clk,
    input  logic                 user_reset,
    input  logic                 cq_valid,
    input  logic                 cq_is_write,
    input  logic                 cq_is_read,
    input  logic [BAR0_SIZE-1:0] cq_reg_addr,
    input  logic [63:0]          cq_wr_data,
    input  logic [2:0]           cq_bar_id,
    input  logic [15:0]          cq_requester_id,
    input  logic [7:0]           cq_tag,
    input  logic [2:0]           cq_tc,
    input  logic [6:0]           cq_lower_addr,
    input  logic [10:0]          cq_dword_count,
    output logic                 reg_wr_en,
    output logic [BAR0_SIZE-1:0] reg_wr_addr,
    output logic [63:0]          reg_wr_data,
    output logic                 reg_rd_en,
    output logic [BAR0_SIZE-1:0] reg_rd_addr,
    input  logic                 reg_rd_valid,
    input  logic [63:0]          reg_rd_data,
    output logic                 cpl_valid,
    output logic [15:0]          cpl_requester_id,
    output logic [7:0]           cpl_tag,
    output logic [2:0]           cpl_tc,
    output logic [6:0]           cpl_lower_addr,
    output logic [10:0]          cpl_dword_count,
    output logic [12:0]          cpl_byte_count,
    output logic [63:0]          cpl_data,
    input  logic                 cpl_ready,
    output logic [15:0]          rd_drop_cnt,
    output logic [15:0]          rd_timeout_cnt
);

    localparam int unsigned PW = $clog2(RD_FIFO_DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam int unsigned TW = $clog2(RD_TIMEOUT + 1);

    typedef struct packed {
        logic [BAR0_SIZE-1:0] addr;
        logic [15:0]          requester_id;
        logic [7:0]           tag;
        logic [2:0]           tc;
        logic [6:0]           lower_addr;
        logic [10:0]          dword_count;
    } rd_req_t;

    typedef enum logic [1:0] {IDLE, RD_REQ, RD_WAIT, CPL} state_t;

    state_t               state_q, state_d;
    rd_req_t              mem_q [RD_FIFO_DEPTH];
    logic [PW-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]        count_q, count_d;
    logic [TW-1:0]        tmo_q, tmo_d;
    logic                 wr_en_q, wr_en_d;
    logic [BAR0_SIZE-1:0] wr_addr_q, wr_addr_d;
    logic [63:0]          wr_data_q, wr_data_d;
    logic                 rd_en_q, rd_en_d;
    logic [BAR0_SIZE-1:0] rd_addr_q, rd_addr_d;
    logic                 cpl_valid_q, cpl_valid_d;
    logic [15:0]          cpl_rid_q, cpl_rid_d;
    logic [7:0]           cpl_tag_q, cpl_tag_d;
    logic [2:0]           cpl_tc_q, cpl_tc_d;
    logic [6:0]           cpl_la_q, cpl_la_d;
    logic [10:0]          cpl_dw_q, cpl_dw_d;
    logic [12:0]          cpl_bc_q, cpl_bc_d;
    logic [63:0]          cpl_data_q, cpl_data_d;
    logic [15:0]          drop_cnt_q, drop_cnt_d;
    logic [15:0]          tmo_cnt_q, tmo_cnt_d;

    logic    acc_wr, acc_rd, push, pop, full, empty;
    rd_req_t head, new_req;

    assign head    = mem_q[rd_ptr_q];
    assign new_req = '{addr: cq_reg_addr, requester_id: cq_requester_id, tag: cq_tag,
                       tc: cq_tc, lower_addr: cq_lower_addr, dword_count: cq_dword_count};
    assign full    = (count_q == CW'(RD_FIFO_DEPTH));
    assign empty   = (count_q == '0);

    // Next-state, FIFO bookkeeping and output register updates
    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        tmo_d       = tmo_q;
        wr_en_d     = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        rd_en_d     = 1'b0;
        rd_addr_d   = rd_addr_q;
        cpl_valid_d = cpl_valid_q;
        cpl_rid_d   = cpl_rid_q;
        cpl_tag_d   = cpl_tag_q;
        cpl_tc_d    = cpl_tc_q;
        cpl_la_d    = cpl_la_q;
        cpl_dw_d    = cpl_dw_q;
        cpl_bc_d    = cpl_bc_q;
        cpl_data_d  = cpl_data_q;
        drop_cnt_d  = drop_cnt_q;
        tmo_cnt_d   = tmo_cnt_q;
        pop         = 1'b0;

        // A request flagged as both write and read is handled as a write
        acc_wr = cq_valid && (cq_bar_id == 3'd0) && cq_is_write;
        acc_rd = cq_valid && (cq_bar_id == 3'd0) && cq_is_read && !cq_is_write;

        if (acc_wr) begin
            wr_en_d   = 1'b1;
            wr_addr_d = cq_reg_addr;
            wr_data_d = cq_wr_data;
        end

        unique case (state_q)
            IDLE: begin
                if (!empty) begin
                    pop       = 1'b1;
                    rd_en_d   = 1'b1;
                    rd_addr_d = head.addr;
                    cpl_rid_d = head.requester_id;
                    cpl_tag_d = head.tag;
                    cpl_tc_d  = head.tc;
                    cpl_la_d  = head.lower_addr;
                    cpl_dw_d  = head.dword_count;
                    // dword_count of zero encodes 1024 DW
                    cpl_bc_d  = (head.dword_count == 11'd0) ? 13'h1000
                                                            : {head.dword_count, 2'b00};
                    state_d   = RD_REQ;
                end
            end
            RD_REQ: begin
                tmo_d   = '0;
                state_d = RD_WAIT;
            end
            RD_WAIT: begin
                // Real data wins over a timeout expiring in the same cycle
                if (reg_rd_valid) begin
                    cpl_data_d  = reg_rd_data;
                    cpl_valid_d = 1'b1;
                    state_d     = CPL;
                end else if (tmo_q == TW'(RD_TIMEOUT - 1)) begin
                    cpl_data_d  = 64'hFFFF_FFFF_FFFF_FFFF;
                    cpl_valid_d = 1'b1;
                    if (tmo_cnt_q != 16'hFFFF) tmo_cnt_d = tmo_cnt_q + 16'd1;
                    state_d     = CPL;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            CPL: begin
                if (cpl_ready) begin
                    cpl_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // A full FIFO still accepts a read when the head is leaving this cycle
        push = acc_rd && (!full || pop);
        if (acc_rd && full && !pop && drop_cnt_q != 16'hFFFF) drop_cnt_d = drop_cnt_q + 16'd1;

        if (push) wr_ptr_d = wr_ptr_q + PW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
        if (push && !pop)      count_d = count_q + CW'(1);
        else if (pop && !push) count_d = count_q - CW'(1);
    end

    // State and output registers
    always_ff @(posedge user_clk or posedge user_reset) begin
        if (user_reset) begin
            state_q     <= IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            tmo_q       <= '0;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            rd_en_q     <= 1'b0;
            rd_addr_q   <= '0;
            cpl_valid_q <= 1'b0;
            cpl_rid_q   <= '0;
            cpl_tag_q   <= '0;
            cpl_tc_q    <= '0;
            cpl_la_q    <= '0;
            cpl_dw_q    <= '0;
            cpl_bc_q    <= '0;
            cpl_data_q  <= '0;
            drop_cnt_q  <= '0;
            tmo_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            tmo_q       <= tmo_d;
            wr_en_q     <= wr_en_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            rd_en_q     <= rd_en_d;
            rd_addr_q   <= rd_addr_d;
            cpl_valid_q <= cpl_valid_d;
            cpl_rid_q   <= cpl_rid_d;
            cpl_tag_q   <= cpl_tag_d;
            cpl_tc_q    <= cpl_tc_d;
            cpl_la_q    <= cpl_la_d;
            cpl_dw_q    <= cpl_dw_d;
            cpl_bc_q    <= cpl_bc_d;
            cpl_data_q  <= cpl_data_d;
            drop_cnt_q  <= drop_cnt_d;
            tmo_cnt_q   <= tmo_cnt_d;
        end
    end

    // FIFO storage; validity is tracked by the pointers, so no reset needed
    always_ff @(posedge user_clk) begin
        if (push) mem_q[wr_ptr_q] <= new_req;
    end

    assign reg_wr_en        = wr_en_q;
    assign reg_wr_addr      = wr_addr_q;
    assign reg_wr_data      = wr_data_q;
    assign reg_rd_en        = rd_en_q;
    assign reg_rd_addr      = rd_addr_q;
    assign cpl_valid        = cpl_valid_q;
    assign cpl_requester_id = cpl_rid_q;
    assign cpl_tag          = cpl_tag_q;
    assign cpl_tc           = cpl_tc_q;
    assign cpl_lower_addr   = cpl_la_q;
    assign cpl_dword_count  = cpl_dw_q;
    assign cpl_byte_count   = cpl_bc_q;
    assign cpl_data         = cpl_data_q;
    assign rd_drop_cnt      = drop_cnt_q;
    assign rd_timeout_cnt   = tmo_cnt_q;

endmodule

// File: tb/tb_cq_req_ctrl.sv
// Directed bench for cq_req_ctrl: inputs driven and outputs sampled on the
// falling edge; a small register-file responder answers reg_rd_en after a
// programmable delay.
module tb_cq_req_ctrl;

    localparam int unsigned T = 10;

    logic        clk = 1'b0;
    logic        rst;
    logic        cq_valid, cq_is_write, cq_is_read;
    logic [15:0] cq_reg_addr;
    logic [63:0] cq_wr_data;
    logic [2:0]  cq_bar_id;
    logic [15:0] cq_requester_id;
    logic [7:0]  cq_tag;
    logic [2:0]  cq_tc;
    logic [6:0]  cq_lower_addr;
    logic [10:0] cq_dword_count;
    logic        reg_wr_en, reg_rd_en, reg_rd_valid, cpl_valid, cpl_ready;
    logic [15:0] reg_wr_addr, reg_rd_addr, cpl_requester_id, rd_drop_cnt, rd_timeout_cnt;
    logic [63:0] reg_wr_data, reg_rd_data, cpl_data;
    logic [7:0]  cpl_tag;
    logic [2:0]  cpl_tc;
    logic [6:0]  cpl_lower_addr;
    logic [10:0] cpl_dword_count;
    logic [12:0] cpl_byte_count;

    int checks   = 0;
    int failures = 0;

    // Responder state
    int          rsp_dly   = 1;
    int          cd        = 0;
    logic        rsp_drove = 1'b0;
    logic        use_fixed = 1'b0;
    logic [63:0] fixed_data = '0;
    logic [15:0] rsp_addr  = '0;

    always #5 clk = ~clk;

    cq_req_ctrl #(.BAR0_SIZE(16), .RD_FIFO_DEPTH(4), .RD_TIMEOUT(T)) dut (
        .user_clk(clk), .user_reset(rst),
        .cq_valid(cq_valid), .cq_is_write(cq_is_write), .cq_is_read(cq_is_read),
        .cq_reg_addr(cq_reg_addr), .cq_wr_data(cq_wr_data), .cq_bar_id(cq_bar_id),
        .cq_requester_id(cq_requester_id), .cq_tag(cq_tag), .cq_tc(cq_tc),
        .cq_lower_addr(cq_lower_addr), .cq_dword_count(cq_dword_count),
        .reg_wr_en(reg_wr_en), .reg_wr_addr(reg_wr_addr), .reg_wr_data(reg_wr_data),
        .reg_rd_en(reg_rd_en), .reg_rd_addr(reg_rd_addr),
        .reg_rd_valid(reg_rd_valid), .reg_rd_data(reg_rd_data),
        .cpl_valid(cpl_valid), .cpl_requester_id(cpl_requester_id), .cpl_tag(cpl_tag),
        .cpl_tc(cpl_tc), .cpl_lower_addr(cpl_lower_addr), .cpl_dword_count(cpl_dword_count),
        .cpl_byte_count(cpl_byte_count), .cpl_data(cpl_data), .cpl_ready(cpl_ready),
        .rd_drop_cnt(rd_drop_cnt), .rd_timeout_cnt(rd_timeout_cnt)
    );

    // Register-file model: reg_rd_valid rsp_dly cycles after reg_rd_en (0 = never)
    always @(negedge clk) begin
        if (rsp_drove) begin
            reg_rd_valid = 1'b0;
            rsp_drove    = 1'b0;
        end
        if (cd > 0) begin
            cd = cd - 1;
            if (cd == 0) begin
                reg_rd_valid = 1'b1;
                reg_rd_data  = use_fixed ? fixed_data : {48'hDA7A_0000_0000, rsp_addr};
                rsp_drove    = 1'b1;
            end
        end
        if (reg_rd_en && rsp_dly > 0) begin
            cd       = rsp_dly;
            rsp_addr = reg_rd_addr;
        end
    end

    // Present one request for a single cycle; returns on the following falling edge
    task automatic send(input logic w, input logic r, input logic [15:0] addr,
                        input logic [63:0] data, input logic [2:0] bar,
                        input logic [7:0] tag, input logic [10:0] dw);
        cq_valid = 1'b1; cq_is_write = w; cq_is_read = r; cq_reg_addr = addr;
        cq_wr_data = data; cq_bar_id = bar; cq_tag = tag; cq_dword_count = dw;
        cq_requester_id = 16'hBEEF; cq_tc = 3'd5; cq_lower_addr = 7'h11;
        @(negedge clk);
        cq_valid = 1'b0; cq_is_write = 1'b0; cq_is_read = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({reg_wr_en, reg_rd_en, cpl_valid} !== 3'b000 || rd_drop_cnt !== 16'h0 ||
            rd_timeout_cnt !== 16'h0 || cpl_data !== 64'h0 || reg_wr_data !== 64'h0) begin
            failures++;
            $display("FAIL reset_outputs got en=%b%b%b drop=%0h tmo=%0h data=%0h exp all zero",
                     reg_wr_en, reg_rd_en, cpl_valid, rd_drop_cnt, rd_timeout_cnt, cpl_data);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_write();
        send(1'b1, 1'b0, 16'h0040, 64'h1122_3344_5566_7788, 3'd0, 8'h0, 11'd1);
        checks++;
        if (reg_wr_en !== 1'b1 || reg_wr_addr !== 16'h0040 ||
            reg_wr_data !== 64'h1122_3344_5566_7788 || cpl_valid !== 1'b0) begin
            failures++;
            $display("FAIL write_pulse got en=%b addr=%h data=%h cpl=%b exp 1 0040 1122334455667788 0",
                     reg_wr_en, reg_wr_addr, reg_wr_data, cpl_valid);
        end
        @(negedge clk);
        checks++;
        if (reg_wr_en !== 1'b0 || cpl_valid !== 1'b0) begin
            failures++;
            $display("FAIL write_one_cycle got en=%b cpl=%b exp 0 0", reg_wr_en, cpl_valid);
        end
    endtask

    task automatic test_read();
        int n;
        rsp_dly = 2; use_fixed = 1'b1; fixed_data = 64'hA5A5; cpl_ready = 1'b0;
        send(1'b0, 1'b1, 16'h0080, 64'h0, 3'd0, 8'h5A, 11'd2);
        n = 1;
        while (!cpl_valid && n < 100) begin @(negedge clk); n++; end
        checks++;
        if (n != 5) begin
            failures++;
            $display("FAIL read_latency got=%0d exp=5", n);
        end
        checks++;
        if (cpl_tag !== 8'h5A || cpl_byte_count !== 13'd8 || cpl_data !== 64'hA5A5 ||
            cpl_dword_count !== 11'd2 || cpl_requester_id !== 16'hBEEF || cpl_tc !== 3'd5 ||
            cpl_lower_addr !== 7'h11 || reg_rd_addr !== 16'h0080) begin
            failures++;
            $display("FAIL read_fields got tag=%h bc=%0d data=%h dw=%0d rid=%h tc=%0d la=%h ra=%h",
                     cpl_tag, cpl_byte_count, cpl_data, cpl_dword_count, cpl_requester_id,
                     cpl_tc, cpl_lower_addr, reg_rd_addr);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (cpl_valid !== 1'b1 || cpl_tag !== 8'h5A || cpl_data !== 64'hA5A5) begin
                failures++;
                $display("FAIL read_hold cycle=%0d got v=%b tag=%h data=%h exp 1 5a a5a5",
                         i, cpl_valid, cpl_tag, cpl_data);
            end
        end
        cpl_ready = 1'b1;
        @(negedge clk);
        cpl_ready = 1'b0;
        checks++;
        if (cpl_valid !== 1'b0) begin
            failures++;
            $display("FAIL read_release got=%b exp=0", cpl_valid);
        end
        use_fixed = 1'b0; rsp_dly = 1;
    endtask

    task automatic test_overflow();
        int got, extra;
        rsp_dly = 1; cpl_ready = 1'b0;
        for (int i = 0; i < 6; i++)
            send(1'b0, 1'b1, 16'h0100 + 16'(8 * i), 64'h0, 3'd0, 8'(i), 11'd1);
        checks++;
        if (rd_drop_cnt !== 16'd1) begin
            failures++;
            $display("FAIL overflow_drop_cnt got=%0d exp=1", rd_drop_cnt);
        end
        cpl_ready = 1'b1;
        got = 0;
        for (int c = 0; c < 200 && got < 5; c++) begin
            if (cpl_valid) begin
                checks++;
                if (cpl_tag !== 8'(got) ||
                    cpl_data !== {48'hDA7A_0000_0000, 16'h0100 + 16'(8 * got)}) begin
                    failures++;
                    $display("FAIL overflow_order idx=%0d got tag=%h data=%h", got, cpl_tag, cpl_data);
                end
                got++;
            end
            @(negedge clk);
        end
        extra = 0;
        for (int c = 0; c < 20; c++) begin
            if (cpl_valid) extra++;
            @(negedge clk);
        end
        checks++;
        if (got != 5 || extra != 0) begin
            failures++;
            $display("FAIL overflow_count got=%0d extra=%0d exp 5 0", got, extra);
        end
        cpl_ready = 1'b0;
    endtask

    task automatic test_timeout();
        int n;
        rsp_dly = 0; cpl_ready = 1'b0;
        send(1'b0, 1'b1, 16'h0200, 64'h0, 3'd0, 8'h77, 11'd1);
        n = 1;
        while (!cpl_valid && n < 100) begin @(negedge clk); n++; end
        checks++;
        if (n != 3 + T || cpl_data !== 64'hFFFF_FFFF_FFFF_FFFF || rd_timeout_cnt !== 16'd1 ||
            cpl_tag !== 8'h77) begin
            failures++;
            $display("FAIL timeout got lat=%0d data=%h cnt=%0d tag=%h exp %0d all-ones 1 77",
                     n, cpl_data, rd_timeout_cnt, cpl_tag, 3 + T);
        end
        cpl_ready = 1'b1; @(negedge clk); cpl_ready = 1'b0;
        // Response lands on the very cycle the timeout expires
        rsp_dly = T; use_fixed = 1'b1; fixed_data = 64'h0123_4567_89AB_CDEF;
        send(1'b0, 1'b1, 16'h0208, 64'h0, 3'd0, 8'h78, 11'd1);
        n = 1;
        while (!cpl_valid && n < 100) begin @(negedge clk); n++; end
        checks++;
        if (n != 3 + T || cpl_data !== 64'h0123_4567_89AB_CDEF || rd_timeout_cnt !== 16'd1) begin
            failures++;
            $display("FAIL timeout_boundary got lat=%0d data=%h cnt=%0d exp %0d 0123456789abcdef 1",
                     n, cpl_data, rd_timeout_cnt, 3 + T);
        end
        cpl_ready = 1'b1; @(negedge clk); cpl_ready = 1'b0;
        use_fixed = 1'b0; rsp_dly = 1;
    endtask

    task automatic test_filter_size();
        int n, seen;
        send(1'b1, 1'b0, 16'h0300, 64'hDEAD, 3'd2, 8'h0, 11'd1);
        checks++;
        if (reg_wr_en !== 1'b0) begin
            failures++;
            $display("FAIL filter_bar2_write got=%b exp=0", reg_wr_en);
        end
        send(1'b0, 1'b1, 16'h0308, 64'h0, 3'd1, 8'h0, 11'd1);
        send(1'b0, 1'b0, 16'h0310, 64'h0, 3'd0, 8'h0, 11'd1);
        seen = 0;
        for (int c = 0; c < 8; c++) begin
            if (reg_rd_en || cpl_valid || reg_wr_en) seen++;
            @(negedge clk);
        end
        checks++;
        if (seen != 0) begin
            failures++;
            $display("FAIL filter_ignored got activity=%0d exp=0", seen);
        end
        send(1'b0, 1'b1, 16'h0320, 64'h0, 3'd0, 8'h33, 11'd0);
        n = 1;
        while (!cpl_valid && n < 100) begin @(negedge clk); n++; end
        checks++;
        if (n != 4 || cpl_byte_count !== 13'h1000 || cpl_dword_count !== 11'd0) begin
            failures++;
            $display("FAIL size_1024dw got lat=%0d bc=%h dw=%0d exp 4 1000 0",
                     n, cpl_byte_count, cpl_dword_count);
        end
        cpl_ready = 1'b1; @(negedge clk); cpl_ready = 1'b0;
    endtask

    task automatic test_reset_mid_read();
        int seen;
        rsp_dly = 0;
        send(1'b0, 1'b1, 16'h0400, 64'h0, 3'd0, 8'h44, 11'd1);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (cpl_valid !== 1'b0 || reg_rd_en !== 1'b0 || rd_drop_cnt !== 16'h0 ||
            rd_timeout_cnt !== 16'h0 || reg_rd_addr !== 16'h0 || cpl_tag !== 8'h0 ||
            cpl_byte_count !== 13'h0 || reg_wr_addr !== 16'h0) begin
            failures++;
            $display("FAIL midread_reset got cpl=%b rd=%b drop=%0d tmo=%0d ra=%h tag=%h bc=%h",
                     cpl_valid, reg_rd_en, rd_drop_cnt, rd_timeout_cnt, reg_rd_addr, cpl_tag,
                     cpl_byte_count);
        end
        rst = 1'b0;
        @(negedge clk);
        reg_rd_valid = 1'b1; reg_rd_data = 64'h5555;
        @(negedge clk);
        reg_rd_valid = 1'b0;
        seen = 0;
        for (int c = 0; c < 10; c++) begin
            if (cpl_valid || reg_rd_en) seen++;
            @(negedge clk);
        end
        checks++;
        if (seen != 0 || rd_drop_cnt !== 16'h0 || rd_timeout_cnt !== 16'h0) begin
            failures++;
            $display("FAIL midread_abandon got activity=%0d drop=%0d tmo=%0d exp 0 0 0",
                     seen, rd_drop_cnt, rd_timeout_cnt);
        end
        rsp_dly = 1;
    endtask

    initial begin
        rst = 1'b1; cq_valid = 1'b0; cq_is_write = 1'b0; cq_is_read = 1'b0;
        cq_reg_addr = '0; cq_wr_data = '0; cq_bar_id = '0; cq_requester_id = '0;
        cq_tag = '0; cq_tc = '0; cq_lower_addr = '0; cq_dword_count = '0;
        reg_rd_valid = 1'b0; reg_rd_data = '0; cpl_ready = 1'b0;
        test_reset();
        test_write();
        test_read();
        test_overflow();
        test_timeout();
        test_filter_size();
        test_reset_mid_read();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cq_req_ctrl.md
CQ_REQ_CTRL -- requirements
Module: cq_req_ctrl

Interface
REQ-001 SHALL have parameter BAR0_SIZE, default 16, meaning byte-address width of the BAR0 register space.
REQ-002 SHALL have parameter RD_FIFO_DEPTH, default 4, meaning number of queued read requests (power of 2, at least 2).
REQ-003 SHALL have parameter RD_TIMEOUT, default 255, meaning maximum cycles spent in RD_WAIT.
REQ-004 SHALL have port user_clk, input, 1 bit: single clock for the whole block.
REQ-005 SHALL have port user_reset, input, 1 bit: asynchronous active-high reset.
REQ-006 SHALL have inputs cq_valid, cq_is_write and cq_is_read, 1 bit each: parsed request qualifiers, with no backpressure available.
REQ-007 SHALL have inputs cq_reg_addr [BAR0_SIZE], cq_wr_data [64] and cq_bar_id [3]: request address, write payload and target BAR.
REQ-008 SHALL have inputs cq_requester_id [16], cq_tag [8], cq_tc [3], cq_lower_addr [7] and cq_dword_count [11]: completion context.
REQ-009 SHALL have outputs reg_wr_en [1], reg_wr_addr [BAR0_SIZE] and reg_wr_data [64]: register-file write port.
REQ-010 SHALL have outputs reg_rd_en [1] and reg_rd_addr [BAR0_SIZE], and inputs reg_rd_valid [1] and reg_rd_data [64]: register-file read port with variable latency.
REQ-011 SHALL have outputs cpl_valid [1], cpl_requester_id [16], cpl_tag [8], cpl_tc [3], cpl_lower_addr [7], cpl_dword_count [11], cpl_byte_count [13] and cpl_data [64], and input cpl_ready [1]: completion request to the completer.
REQ-012 SHALL have outputs rd_drop_cnt [16] and rd_timeout_cnt [16]: saturating status counters.

Function
REQ-013 SHALL act only on requests with cq_valid=1 and cq_bar_id=0; all other requests are ignored with no side effects.
REQ-014 SHALL, for an accepted write, drive reg_wr_en=1 for exactly one cycle, the cycle after the request, with the captured address and data; writes are posted and produce no completion.
REQ-015 SHALL, for an accepted read, push {addr, requester_id, tag, tc, lower_addr, dword_count} into the read FIFO in the request cycle.
REQ-016 SHALL, on a read arriving while the FIFO is full, drop the read and increment rd_drop_cnt, saturating at 16'hFFFF.
REQ-017 SHALL implement read FSM state IDLE: if the FIFO is non-empty, pop the head into working registers and go to RD_REQ.
REQ-018 SHALL implement read FSM state RD_REQ: drive reg_rd_en=1 for one cycle with reg_rd_addr set to the head address, clear the timeout counter, and go to RD_WAIT.
REQ-019 SHALL implement read FSM state RD_WAIT: on reg_rd_valid, latch reg_rd_data and go to CPL; otherwise increment the timeout counter.
REQ-020 SHALL, when the RD_WAIT timeout counter reaches RD_TIMEOUT, latch data 64'hFFFF_FFFF_FFFF_FFFF, increment rd_timeout_cnt (saturating), and go to CPL.
REQ-021 SHALL, when reg_rd_valid is asserted on the same cycle the timeout expires, take the real data and leave rd_timeout_cnt unchanged.
REQ-022 SHALL implement read FSM state CPL: hold cpl_valid=1 with all cpl_* outputs stable until cpl_ready=1, then return to IDLE.
REQ-023 SHALL ignore reg_rd_valid outside RD_WAIT.
REQ-024 SHALL have only one read outstanding; minimum request-to-cpl_valid latency is 4 cycles (push, IDLE pop, RD_REQ, RD_WAIT with immediate reg_rd_valid).
REQ-025 SHALL compute cpl_byte_count = cpl_dword_count × 4, with dword_count=0 meaning 1024 DW, giving 13'h1000.
REQ-026 SHALL allow a FIFO push and pop in the same cycle, including when the FIFO is full, with the occupancy unchanged; pointers wrap modulo RD_FIFO_DEPTH.
REQ-027 SHALL keep writes and reads independent: a write accepted in cycle N is visible to any read whose reg_rd_en occurs in cycle N+2 or later.
REQ-028 SHALL treat a request with both cq_is_write and cq_is_read low as ignored.

Reset
REQ-029 SHALL, while user_reset=1, force the FSM to IDLE, empty the FIFO, and drive reg_wr_en, reg_rd_en and cpl_valid to 0, rd_drop_cnt and rd_timeout_cnt to 0, and all data and address outputs to 0.
REQ-030 SHALL, on reset asserted mid-read (RD_WAIT or CPL), abandon the read with no completion issued and ignore any later reg_rd_valid for it.

Verification
REQ-031 Single write: addr 0x0040, data 0x1122334455667788, bar 0 -> reg_wr_en pulses one cycle later with the same values; cpl_valid stays 0.
REQ-032 Single read: addr 0x0080, dword_count 2, tag 0x5A, reg_rd_valid 2 cycles after reg_rd_en with data 0xA5A5 -> cpl_valid with tag 0x5A, byte_count 8, data 0xA5A5; held through 3 cycles of cpl_ready=0.
REQ-033 Overflow: 6 back-to-back reads with cpl_ready=0 and RD_FIFO_DEPTH=4 -> 1 in flight, 4 queued, 1 dropped; rd_drop_cnt=1; five completions in order after cpl_ready rises.
REQ-034 Timeout: read with reg_rd_valid never asserted -> cpl_data all ones exactly RD_TIMEOUT cycles into RD_WAIT, rd_timeout_cnt=1; boundary case with reg_rd_valid on the expiry cycle -> real data returned, count unchanged.
REQ-035 Filtering and size: write to bar_id 2 -> no reg_wr_en; read with dword_count 0 -> cpl_byte_count 13'h1000.
REQ-036 Reset mid-read: assert user_reset while in RD_WAIT, then pulse reg_rd_valid after release -> no cpl_valid, FIFO empty, counters 0.
